// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit pair per clock through a 1-bit full-adder cell.
// Operands and results move over valid/ready handshakes.

module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);
    localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    full_adder_1bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (i_valid) state_next = RUN;
            RUN:  if (cnt == LAST) state_next = DONE;
            DONE: if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // New sum bits enter at the MSB so that after WIDTH shifts bit 0 lands in the LSB.
    always_comb begin
        sum_next = sum_sh >> 1;
        sum_next[WIDTH-1] = fa_sum;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_sh  <= i_a;
                        b_sh  <= i_b;
                        carry <= i_cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= sum_next;
                    carry  <= fa_cout;
                    cnt    <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Ready is forced low during reset so nothing is accepted while the block is being cleared.
    assign o_ready = (state == IDLE) && !i_rst;
    assign o_valid = (state == DONE);
    assign o_sum   = sum_sh;
    assign o_carry = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8 and WIDTH=1.

module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;
    logic       valid8, ready_in8, cin8;
    logic [7:0] a8, b8;
    logic       rdy8, ovld8, carry8;
    logic [7:0] sum8;
    logic       valid1, ready_in1, cin1;
    logic [0:0] a1, b1;
    logic       rdy1, ovld1, carry1;
    logic [0:0] sum1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid8), .o_ready(rdy8),
        .i_a(a8), .i_b(b8), .i_cin(cin8), .o_valid(ovld8), .i_ready(ready_in8),
        .o_sum(sum8), .o_carry(carry8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid1), .o_ready(rdy1),
        .i_a(a1), .i_b(b1), .i_cin(cin1), .o_valid(ovld1), .i_ready(ready_in1),
        .o_sum(sum1), .o_carry(carry1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full WIDTH=8 transaction: accept, check latency, check result, optionally release.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c, input bit release_out);
        logic [8:0] exp;
        int waited;
        exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
        waited = 0;
        while (!rdy8 && waited < 20) begin
            tick();
            waited++;
        end
        chk("accept_ready", {31'd0, rdy8}, 32'd1);
        valid8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        tick();
        valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("run_valid", {31'd0, ovld8}, 32'd0);
            chk("run_ready", {31'd0, rdy8}, 32'd0);
            tick();
        end
        chk("done_valid", {31'd0, ovld8}, 32'd1);
        chk("done_ready", {31'd0, rdy8}, 32'd0);
        chk("sum", {24'd0, sum8}, {24'd0, exp[7:0]});
        chk("carry", {31'd0, carry8}, {31'd0, exp[8]});
        if (release_out) begin
            ready_in8 = 1'b1;
            tick();
            ready_in8 = 1'b0;
            chk("release_valid", {31'd0, ovld8}, 32'd0);
            chk("release_ready", {31'd0, rdy8}, 32'd1);
        end
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        rst = 1'b1;
        valid8 = 1'b0; ready_in8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        valid1 = 1'b0; ready_in1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", {31'd0, rdy8}, 32'd0);
        chk("rst_valid", {31'd0, ovld8}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, rdy8}, 32'd1);
        chk("post_rst_valid", {31'd0, ovld8}, 32'd0);
        chk("post_rst_sum", {24'd0, sum8}, 32'd0);
        chk("post_rst_carry", {31'd0, carry8}, 32'd0);
        chk("post_rst_ready_w1", {31'd0, rdy1}, 32'd1);

        // Directed additions (operands zeroed right after accept inside run8)
        run8(8'hFF, 8'h01, 1'b0, 1'b1);
        run8(8'hA5, 8'h5A, 1'b1, 1'b1);

        // Backpressure in DONE with i_valid pulses
        run8(8'h3C, 8'h4B, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            valid8 = (i % 2 == 0);
            a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1;
            tick();
            chk("bp_valid", {31'd0, ovld8}, 32'd1);
            chk("bp_ready", {31'd0, rdy8}, 32'd0);
            chk("bp_sum", {24'd0, sum8}, 32'h88);
            chk("bp_carry", {31'd0, carry8}, 32'd0);
        end
        valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        ready_in8 = 1'b1;
        tick();
        ready_in8 = 1'b0;
        chk("bp_release_ready", {31'd0, rdy8}, 32'd1);
        chk("bp_release_valid", {31'd0, ovld8}, 32'd0);

        // Reset at RUN cycle 3
        valid8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b0;
        tick();
        valid8 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, rdy8}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_valid", {31'd0, ovld8}, 32'd0);
        chk("abort_sum", {24'd0, sum8}, 32'd0);
        chk("abort_carry", {31'd0, carry8}, 32'd0);
        chk("abort_ready", {31'd0, rdy8}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_valid", {31'd0, ovld8}, 32'd0);
        end
        run8(8'h12, 8'h34, 1'b0, 1'b1);

        // Random back-to-back with i_ready high
        for (int n = 0; n < 100; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            run8(ra, rb, rc, 1'b1);
        end

        // WIDTH=1
        chk("w1_ready", {31'd0, rdy1}, 32'd1);
        valid1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        tick();
        valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        chk("w1_run_valid", {31'd0, ovld1}, 32'd0);
        chk("w1_run_ready", {31'd0, rdy1}, 32'd0);
        tick();
        chk("w1_valid", {31'd0, ovld1}, 32'd1);
        chk("w1_sum", {31'd0, sum1}, 32'd1);
        chk("w1_carry", {31'd0, carry1}, 32'd1);
        ready_in1 = 1'b1;
        tick();
        ready_in1 = 1'b0;
        chk("w1_release_ready", {31'd0, rdy1}, 32'd1);
        chk("w1_release_valid", {31'd0, ovld1}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around the team's `full_adder_1bit` cell. It accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It feeds one bit pair per clock into the full adder and registers the cell's carry back into its carry-in. It presents the WIDTH-bit sum and final carry on an output valid/ready handshake. It is the sequencing stage that drives and consumes the 1-bit full adder, trading latency for area in multi-bit datapaths.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal values are 1 and above.

- `i_clk` input, 1 bit: clock; all state changes on the rising edge.
- `i_rst` input, 1 bit: reset, synchronous and active-high.
- `i_valid` input, 1 bit: operands present on `i_a`, `i_b`, `i_cin`.
- `o_ready` output, 1 bit: block can accept operands.
- `i_a` input, WIDTH bits: operand A.
- `i_b` input, WIDTH bits: operand B.
- `i_cin` input, 1 bit: carry-in to bit 0.
- `o_valid` output, 1 bit: result present on `o_sum`/`o_carry`.
- `i_ready` input, 1 bit: downstream accepts the result.
- `o_sum` output, WIDTH bits: sum, equal to (A + B + cin) mod 2^WIDTH.
- `o_carry` output, 1 bit: carry out of bit WIDTH-1.

## Operation
- States:
  - IDLE: `o_ready`=1.
  - RUN: `o_ready`=0, `o_valid`=0.
  - DONE: `o_ready`=0, `o_valid`=1.
- Accept:
  - In IDLE with `i_valid`=1 at an edge, capture `i_a`/`i_b` into shift registers and `i_cin` into the carry register.
  - On the same edge, clear the bit counter and move to RUN.
- RUN, every cycle:
  - Drive bit 0 of the A/B shift registers and the carry register into `full_adder_1bit`.
  - On the edge, shift the cell's sum bit into the sum register at the MSB, with a right shift.
  - On the same edge, shift A/B right, load the cell's carry into the carry register, and increment the counter.
- RUN to DONE: on the edge where the counter equals WIDTH-1. After this edge, `o_sum` holds the full result with bit 0 in the LSB, and `o_carry` equals the carry register.
- DONE to IDLE: on an edge with `i_ready`=1.
- DONE holds `o_valid`, `o_sum` and `o_carry` stable for as long as `i_ready`=0.
- `i_valid` is ignored in RUN and DONE. Input changes after the accept edge do not affect the result.
- `o_sum`/`o_carry` are defined only while `o_valid`=1. Intermediate shifting is visible but must not be checked.
- Counter width is clog2(WIDTH+1), with a minimum of 1 bit.
- Arithmetic is unsigned, and no overflow flag is produced beyond `o_carry`.
- Reset (`i_rst`=1 at an edge):
  - state goes to IDLE;
  - `o_valid`=0, `o_sum`=0, `o_carry`=0;
  - counter and shift registers are cleared.
- While `i_rst`=1, `o_ready` is forced to 0 and `i_valid` is ignored.
- Reset mid-RUN or mid-DONE aborts the operation; no result is ever presented for it.
- Outputs are registered or decoded from state only. There is no combinational path from `i_valid`/`i_ready` to `o_ready`/`o_valid`.

## Timing
- Latency: if the accept handshake occurs at edge k, `o_valid` is 1 immediately after edge k+WIDTH.
- Output handshake at edge m: `o_valid`=0 and `o_ready`=1 immediately after edge m. The next accept is possible at edge m+1 at the earliest.
- Throughput: one addition per WIDTH+2 cycles with `i_ready` tied high.
- WIDTH=1: one RUN cycle. RUN goes to DONE on the first RUN edge, since the counter starts at 0 = WIDTH-1.
- First cycle after reset deasserts: `o_ready`=1, `o_valid`=0.

## Test plan
- WIDTH=8, a=8'hFF, b=8'h01, cin=0:
  - `o_sum`=8'h00 and `o_carry`=1;
  - `o_valid` rises right after edge k+8;
  - `o_ready`=0 throughout RUN/DONE.
- WIDTH=8, a=8'hA5, b=8'h5A, cin=1:
  - `o_sum`=8'h00, `o_carry`=1;
  - operands changed to 8'h00 one cycle after accept must not alter the result.
- Backpressure: hold `i_ready`=0 for 5 cycles in DONE while pulsing `i_valid`.
  - `o_valid`, `o_sum` and `o_carry` stay stable and `o_ready` stays 0.
  - The `i_valid` pulses are ignored.
  - After `i_ready`=1, `o_ready`=1 on the next cycle.
- Reset mid-operation: assert `i_rst` at RUN cycle 3 with a=8'hF0, b=8'h0F.
  - `o_valid` is never asserted for that operation, and outputs are 0.
  - Then a=8'h12, b=8'h34, cin=0 gives `o_sum`=8'h46, `o_carry`=0.
- Random back-to-back: 100 operations, `i_ready` tied high, compared against {carry,sum} = a + b + cin.
  - All pass.
  - Each `o_valid` arrives WIDTH edges after its accept.
- WIDTH=1: a=1, b=1, cin=1 gives `o_sum`=1, `o_carry`=1, with `o_valid` right after edge k+1.
